// File: rtl/quad_decoder_counter_if.sv
// Encoder-side bus for quad_decoder_counter: phase pins, parallel load and position/step outputs.
interface quad_decoder_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             a_in;
    logic             b_in;
    logic             ld;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             step;
    logic             dir;
    logic             err;

    modport master (
        output a_in, b_in, ld, D,
        input  Q, step, dir, err
    );

    modport slave (
        input  a_in, b_in, ld, D,
        output Q, step, dir, err
    );
endinterface

// File: rtl/quad_decoder_counter.sv
// Quadrature A/B decoder: 2-flop sync, per-phase glitch filter, Gray decode FSM and
// up/down position counter with parallel load and sticky illegal-transition flag.
module quad_decoder_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FILT  = 2
) (
    input logic                    clk,
    input logic                    rt_n,
    quad_decoder_counter_if.slave  bus
);
    localparam int unsigned FCNT_W = 4;
    // INIT lasts until the sync+filter pipeline has settled on the pin levels at release.
    localparam int unsigned SETTLE = FILT + 3;
    localparam int unsigned INIT_W = $clog2(SETTLE + 1);

    if (FILT < 1 || FILT > 15) begin : g_filt_range
        $error("quad_decoder_counter: FILT must be in 1..15");
    end

    typedef enum logic {INIT, TRACK} state_t;

    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0]        filt;
    logic [FCNT_W-1:0] fcnt [2];

    state_t            state, state_n;
    logic [INIT_W-1:0] init_cnt, init_cnt_n;
    logic [1:0]        latched, latched_n;
    logic [WIDTH-1:0]  q, q_n;
    logic              step, step_n;
    logic              dir, dir_n;
    logic              err, err_n;

    // Pair encoding is {A,B}; up order 00->10->11->01->00.
    function automatic logic [1:0] up_next(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] down_next(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Synchronizer and glitch filter; a phase flips only after FILT consecutive differing samples.
    always_ff @(posedge clk or negedge rt_n) begin
        if (!rt_n) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1 <= {bus.a_in, bus.b_in};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (fcnt[i] == FCNT_W'(FILT - 1)) begin
                        filt[i] <= sync2[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + FCNT_W'(1);
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rt_n) begin
        if (!rt_n) begin
            state    <= INIT;
            init_cnt <= '0;
            latched  <= '0;
            q        <= '0;
            step     <= 1'b0;
            dir      <= 1'b1;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            init_cnt <= init_cnt_n;
            latched  <= latched_n;
            q        <= q_n;
            step     <= step_n;
            dir      <= dir_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        init_cnt_n = init_cnt;
        latched_n  = latched;
        q_n        = q;
        step_n     = 1'b0;
        dir_n      = dir;
        err_n      = err;

        case (state)
            INIT: begin
                latched_n = filt;
                if (init_cnt == INIT_W'(SETTLE - 1)) state_n = TRACK;
                else                                 init_cnt_n = init_cnt + INIT_W'(1);
            end
            TRACK: begin
                if (filt != latched) begin
                    latched_n = filt;
                    if (filt == up_next(latched)) begin
                        step_n = 1'b1;
                        dir_n  = 1'b1;
                        q_n    = q + WIDTH'(1);
                    end else if (filt == down_next(latched)) begin
                        step_n = 1'b1;
                        dir_n  = 1'b0;
                        q_n    = q - WIDTH'(1);
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            default: state_n = INIT;
        endcase

        // Load wins over a same-cycle count; step/dir still report the transition.
        if (bus.ld) begin
            q_n   = bus.D;
            err_n = 1'b0;
        end
    end

    assign bus.Q    = q;
    assign bus.step = step;
    assign bus.dir  = dir;
    assign bus.err  = err;
endmodule

// File: tb/tb_quad_decoder_counter.sv
// Randomized bench for quad_decoder_counter against a pin-level position model.
module tb_quad_decoder_counter;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned FILT  = 2;
    localparam int unsigned HOLD  = 10;

    logic clk  = 1'b0;
    logic rt_n = 1'b0;

    quad_decoder_counter_if #(.WIDTH(WIDTH)) bus ();

    quad_decoder_counter #(.WIDTH(WIDTH), .FILT(FILT)) dut (
        .clk  (clk),
        .rt_n (rt_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int steps   = 0;

    logic [WIDTH-1:0] m_q;
    logic             m_dir;
    logic             m_err;
    logic [1:0]       m_pair;
    int               m_steps;

    always @(negedge clk) if (bus.step === 1'b1) steps++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Position of a pair along the up cycle 00,10,11,01.
    function automatic int gray_idx(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray_at(input int i);
        logic [1:0] tbl [4];
        tbl[0] = 2'b00; tbl[1] = 2'b10; tbl[2] = 2'b11; tbl[3] = 2'b01;
        return tbl[i % 4];
    endfunction

    task automatic model_move(input logic [1:0] p);
        int d;
        m_steps = 0;
        if (p == m_pair) return;
        d = (gray_idx(p) - gray_idx(m_pair) + 4) % 4;
        if (d == 1) begin
            m_q = m_q + 1'b1; m_dir = 1'b1; m_steps = 1;
        end else if (d == 3) begin
            m_q = m_q - 1'b1; m_dir = 1'b0; m_steps = 1;
        end else begin
            m_err = 1'b1;
        end
        m_pair = p;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".Q"},   32'(bus.Q),   32'(m_q));
        check({tag, ".dir"}, 32'(bus.dir), 32'(m_dir));
        check({tag, ".err"}, 32'(bus.err), 32'(m_err));
    endtask

    task automatic apply_pair(input logic [1:0] p, input string tag);
        int s0;
        @(negedge clk);
        s0 = steps;
        bus.a_in = p[1];
        bus.b_in = p[0];
        model_move(p);
        repeat (HOLD) @(negedge clk);
        check_state(tag);
        check({tag, ".steps"}, 32'(steps - s0), 32'(m_steps));
    endtask

    task automatic do_load(input logic [WIDTH-1:0] d, input string tag);
        @(negedge clk);
        bus.ld = 1'b1;
        bus.D  = d;
        @(negedge clk);
        bus.ld = 1'b0;
        m_q    = d;
        m_err  = 1'b0;
        check_state(tag);
    endtask

    task automatic glitch(input int bitn, input string tag);
        int s0;
        @(negedge clk);
        s0 = steps;
        if (bitn == 1) bus.a_in = ~bus.a_in; else bus.b_in = ~bus.b_in;
        @(negedge clk);
        if (bitn == 1) bus.a_in = ~bus.a_in; else bus.b_in = ~bus.b_in;
        repeat (HOLD) @(negedge clk);
        check_state(tag);
        check({tag, ".steps"}, 32'(steps - s0), 32'd0);
    endtask

    task automatic do_reset(input logic [1:0] pins, input string tag);
        rt_n     = 1'b0;
        bus.a_in = pins[1];
        bus.b_in = pins[0];
        bus.ld   = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, ".rQ"},    32'(bus.Q),    32'd0);
        check({tag, ".rstep"}, 32'(bus.step), 32'd0);
        check({tag, ".rdir"},  32'(bus.dir),  32'd1);
        check({tag, ".rerr"},  32'(bus.err),  32'd0);
        rt_n = 1'b1;
        repeat (FILT + 8) @(negedge clk);
        m_q = '0; m_dir = 1'b1; m_err = 1'b0; m_pair = pins;
        check_state(tag);
    endtask

    initial begin
        int r;
        logic [1:0] p;
        bus.a_in = 1'b0; bus.b_in = 1'b0; bus.ld = 1'b0; bus.D = '0;
        m_q = '0; m_dir = 1'b1; m_err = 1'b0; m_pair = 2'b00; m_steps = 0;

        do_reset(2'b00, "rst0");

        // First up edge with exact step latency and width.
        @(negedge clk);
        bus.a_in = 1'b1;
        model_move(2'b10);
        for (int k = 1; k <= int'(FILT) + 4; k++) begin
            @(negedge clk);
            check("lat.step", 32'(bus.step), 32'(k == int'(FILT) + 3));
        end
        check_state("up1");
        apply_pair(2'b11, "up2");
        apply_pair(2'b01, "up3");
        apply_pair(2'b00, "up4");

        do_load(8'h01, "ld01");
        apply_pair(2'b01, "dn1");
        apply_pair(2'b11, "dn2");
        apply_pair(2'b10, "dn3");

        glitch(1, "glitchA");
        glitch(0, "glitchB");

        apply_pair(2'b00, "pre_ill");
        apply_pair(2'b11, "ill");
        apply_pair(2'b01, "post_ill");
        do_load(8'h55, "ld55");

        // Load landing on the same edge as a legal up count.
        do_load(8'h10, "ld10");
        p = gray_at(gray_idx(m_pair) + 1);
        @(negedge clk);
        bus.a_in = p[1];
        bus.b_in = p[0];
        repeat (FILT + 2) @(negedge clk);
        bus.ld = 1'b1;
        bus.D  = 8'hA0;
        @(negedge clk);
        bus.ld = 1'b0;
        check("ldcnt.step", 32'(bus.step), 32'd1);
        check("ldcnt.Q",    32'(bus.Q),    32'hA0);
        check("ldcnt.dir",  32'(bus.dir),  32'd1);
        m_q = 8'hA0; m_dir = 1'b1; m_err = 1'b0; m_pair = p;
        repeat (HOLD) @(negedge clk);
        check_state("ldcnt.after");

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 3)      apply_pair(gray_at(gray_idx(m_pair) + 1), "rnd.up");
            else if (r <= 6) apply_pair(gray_at(gray_idx(m_pair) + 3), "rnd.dn");
            else if (r == 7) apply_pair(m_pair ^ 2'b11, "rnd.ill");
            else if (r == 8) glitch(int'($urandom_range(0, 1)), "rnd.glitch");
            else             do_load(WIDTH'($urandom), "rnd.ld");
        end

        do_reset(2'b11, "rst11");
        apply_pair(2'b01, "rst11.up");

        // Async reset in the middle of a filter run, between clock edges.
        do_load(8'h5A, "pre_async");
        apply_pair(2'b11, "pre_async.dn");
        apply_pair(2'b00, "pre_async.ill");
        @(negedge clk);
        bus.a_in = 1'b0; bus.b_in = 1'b1;
        @(negedge clk);
        #2 rt_n = 1'b0;
        #1;
        check("async.Q",    32'(bus.Q),    32'd0);
        check("async.step", 32'(bus.step), 32'd0);
        check("async.dir",  32'(bus.dir),  32'd1);
        check("async.err",  32'(bus.err),  32'd0);
        @(negedge clk);
        do_reset(2'b01, "rst01");
        apply_pair(2'b00, "rst01.up");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
